// File: rtl/collision_report_buffer.sv
// Collision report buffer: captures collision line IDs into a show-ahead FIFO and
// streams them out on valid/ready. Optional duplicate suppression via `DEDUP_EN.
module collision_report_buffer #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_val,
  input  logic [ID_W-1:0]          lineID,
  output logic                     out_val,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         count
);

  localparam int AW = $clog2(DEPTH);

  logic [ID_W-1:0] mem_r [DEPTH];
  logic [AW:0]     wr_ptr_r;
  logic [AW:0]     rd_ptr_r;
  logic [AW:0]     wr_ptr_nxt_s;
  logic [AW:0]     rd_ptr_nxt_s;
  logic [AW:0]     level_nxt_s;
  logic            full_nxt_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic            dup_s;

`ifdef DEDUP_EN
  logic [ID_W-1:0] last_id_r;
  logic            last_vld_r;

  // A pulse repeating the last accepted ID is treated as if it never arrived.
  always_comb begin
    dup_s = last_vld_r & (lineID == last_id_r);
  end

  // Track the most recently accepted ID; it survives the entry being popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_id_r  <= {ID_W{1'b0}};
      last_vld_r <= 1'b0;
    end else if (clear) begin
      last_id_r  <= {ID_W{1'b0}};
      last_vld_r <= 1'b0;
    end else if (push_s) begin
      last_id_r  <= lineID;
      last_vld_r <= 1'b1;
    end else begin
      last_id_r  <= last_id_r;
      last_vld_r <= last_vld_r;
    end
  end
`else
  always_comb begin
    dup_s = 1'b0;
  end
`endif

  // Push/pop/drop decisions and next-state pointers; clear masks all traffic.
  always_comb begin
    pop_s        = out_val & out_rdy & ~clear;
    push_s       = in_val & ~dup_s & (~full | pop_s) & ~clear;
    drop_s       = in_val & ~dup_s & full & ~pop_s & ~clear;
    wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, push_s};
    rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
    level_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_nxt_s   = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                   (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
  end

  // Storage array; the read side is masked by out_val so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= lineID;
    end
  end

  // Show-ahead head: visible as soon as out_val rises, zero while empty.
  always_comb begin
    out_id = out_val ? mem_r[rd_ptr_r[AW-1:0]] : {ID_W{1'b0}};
  end

  // FIFO pointers, registered status, saturating counter and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      level    <= {(AW+1){1'b0}};
      full     <= 1'b0;
      out_val  <= 1'b0;
      overflow <= 1'b0;
      count    <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      level    <= {(AW+1){1'b0}};
      full     <= 1'b0;
      out_val  <= 1'b0;
      overflow <= 1'b0;
      count    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level    <= level_nxt_s;
      full     <= full_nxt_s;
      out_val  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
      if (push_s && (count != {CNT_W{1'b1}})) begin
        count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count <= count;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_collision_report_buffer.sv
// Self-checking bench for collision_report_buffer: vector table plus directed
// multi-cycle sequences, with a queue scoreboard for the emitted IDs.
module tb_collision_report_buffer;

  localparam int ID_W  = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              in_val;
  logic [ID_W-1:0]   lineID;
  logic              out_val;
  logic [ID_W-1:0]   out_id;
  logic              out_rdy;
  logic [4:0]        level;
  logic              full;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int         m_cnt  = 0;
  bit         m_ovf  = 1'b0;
  bit         m_lvld = 1'b0;
  logic [7:0] m_last = 8'd0;

  typedef struct {
    logic       v;
    logic [7:0] id;
    logic       rdy;
    logic       clr;
    int         exp_level;
    int         exp_count;
  } vec_t;
  vec_t vec[$];

  collision_report_buffer #(.ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_val(in_val), .lineID(lineID),
    .out_val(out_val), .out_id(out_id), .out_rdy(out_rdy), .level(level),
    .full(full), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_lvld = 1'b0;
  endtask

  // One clock: drive inputs, check head at negedge, update model, check state after edge.
  task automatic cycle(input logic v, input logic [7:0] id, input logic rdy, input logic clr);
    bit pop, dup, was_full;
    in_val = v; lineID = id; out_rdy = rdy; clear = clr;
    @(negedge clk);
    chk("out_val_pre", int'(out_val), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_id", int'(out_id), int'(exp_q[0]));
    dup = 1'b0;
`ifdef DEDUP_EN
    dup = m_lvld && (id == m_last);
`endif
    was_full = (exp_q.size() == DEPTH);
    pop = (exp_q.size() != 0) && rdy && !clr;
    if (clr) begin
      model_clear();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (v && !dup && (!was_full || pop)) begin
        exp_q.push_back(id);
        if (m_cnt < 65535) m_cnt++;
        m_lvld = 1'b1;
        m_last = id;
      end else if (v && !dup) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("level", int'(level), exp_q.size());
    chk("full", int'(full), int'(exp_q.size() == DEPTH));
    chk("out_val", int'(out_val), int'(exp_q.size() != 0));
    chk("count", int'(count), m_cnt);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_val = 1'b0; lineID = 8'd0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_full", int'(full), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // T2: ordered output with backpressure, then drain.
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b0, 1'b1, 0, 0});
    vec.push_back(vec_t'{1'b1, 8'd3, 1'b0, 1'b0, 1, 1});
    vec.push_back(vec_t'{1'b1, 8'd7, 1'b0, 1'b0, 2, 2});
    vec.push_back(vec_t'{1'b1, 8'd9, 1'b0, 1'b0, 3, 3});
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 2, 3});
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 1, 3});
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 0, 3});
    // T6: repeated IDs.
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b0, 1'b1, 0, 0});
`ifdef DEDUP_EN
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 1, 1});
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 1, 1});
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 1, 1});
    vec.push_back(vec_t'{1'b1, 8'd6, 1'b0, 1'b0, 2, 2});
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 3, 3});
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 2, 3});
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 1, 3});
    vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 0, 3});
`else
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 1, 1});
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 2, 2});
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 3, 3});
    vec.push_back(vec_t'{1'b1, 8'd6, 1'b0, 1'b0, 4, 4});
    vec.push_back(vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 5, 5});
    for (int i = 4; i >= 0; i--) vec.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, i, 5});
`endif
    foreach (vec[i]) begin
      cycle(vec[i].v, vec[i].id, vec[i].rdy, vec[i].clr);
      chk("tbl_level", int'(level), vec[i].exp_level);
      chk("tbl_count", int'(count), vec[i].exp_count);
    end

    // T3: overfill drops two entries and sets the sticky flag.
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t3_full", int'(full), 1);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_count", int'(count), 16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t3_overflow_sticky", int'(overflow), 1);

    // T4: push into a full FIFO alongside a pop is accepted.
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(100 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'd42, 1'b1, 1'b0);
    chk("t4_level", int'(level), 16);
    chk("t4_overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // T5: clear wins over a simultaneous pulse.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(200 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'd5, 1'b1, 1'b1);
    chk("t5_level", int'(level), 0);
    chk("t5_count", int'(count), 0);
    chk("t5_out_val", int'(out_val), 0);
    repeat (3) cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // T1: asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(50 + i), 1'b0, 1'b0);
    in_val = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t1_out_val", int'(out_val), 0);
    chk("t1_level", int'(level), 0);
    chk("t1_count", int'(count), 0);
    chk("t1_overflow", int'(overflow), 0);
    model_clear();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'd11, 1'b0, 1'b0);
    cycle(1'b1, 8'd12, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t1_resume_count", int'(count), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
